seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, the number of bits per serial word.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 3, the idle bit-times inserted after each word (0 allowed).
REQ-003 The module SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 The module SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port WORD  input  WIDTH  parallel word to transmit, bit 0 sent first.
REQ-006 The module SHALL have port LOAD_VALID  input  1  WORD is valid for acceptance.
REQ-007 The module SHALL have port LOAD_READY  output  1  the holding register can accept a word.
REQ-008 The module SHALL have port DATA  output  1  serial bit stream, one bit per clock.
REQ-009 The module SHALL have port DATA_VALID  output  1  DATA carries a word bit this cycle.
REQ-010 The module SHALL have port DONE  output  1  high during the cycle the last bit (WIDTH-1) of a word is on DATA.
REQ-011 The module SHALL have port BUSY  output  1  state is not IDLE.
REQ-012 The module SHALL have port WORD_CNT  output  8  count of completed words.

Function
REQ-013 The module SHALL contain a one-entry holding register; LOAD_READY SHALL be the negation of hold_full (registered, no combinational path from LOAD_VALID).
REQ-014 A word SHALL be accepted on an edge where LOAD_VALID && LOAD_READY; WORD is captured and hold_full is set.
REQ-015 The FSM SHALL have states IDLE, SHIFT and GAP; all outputs SHALL be registered.
REQ-016 In IDLE with hold_full=1, the next edge SHALL move the word to the shift register, clear hold_full, enter SHIFT, and drive DATA=WORD[0], DATA_VALID=1.
REQ-017 Acceptance-to-first-bit latency SHALL be one cycle: a word accepted at edge k from IDLE with an empty holding register has bit 0 on DATA after edge k+1.
REQ-018 In SHIFT, each edge SHALL advance to the next bit; bit i is on DATA for exactly one cycle, in order 0..WIDTH-1.
REQ-019 After the last bit: GAP_CYCLES>0 -> GAP for exactly GAP_CYCLES cycles with DATA=0, DATA_VALID=0; GAP_CYCLES=0 -> handled as end of GAP immediately.
REQ-020 At the end of GAP: hold_full=1 -> SHIFT with bit 0 of the held word on the next cycle (no extra idle); otherwise -> IDLE with DATA=0, DATA_VALID=0.
REQ-021 With GAP_CYCLES=0 and hold_full=1, consecutive words SHALL be sent back-to-back with DATA_VALID continuously high.
REQ-022 When an edge both transfers the held word and accepts a new word, the new word SHALL land in the holding register (hold_full stays 1); no word is lost or duplicated.
REQ-023 When LOAD_READY=0, LOAD_VALID SHALL be ignored and the held word SHALL stay unchanged.
REQ-024 WORD_CNT SHALL increment on the edge that ends the last bit of each word and SHALL wrap from 255 to 0.
REQ-025 BUSY SHALL be 1 in SHIFT and GAP and 0 in IDLE; DONE SHALL be a one-cycle pulse per word.

Reset
REQ-026 On any rising edge with RST=0, the FSM SHALL go to IDLE, hold_full and the shift register SHALL clear, and outputs SHALL be DATA=0, DATA_VALID=0, DONE=0, BUSY=0, WORD_CNT=0, LOAD_READY=1.
REQ-027 Reset asserted mid-word SHALL discard the in-flight and held words without incrementing WORD_CNT; LOAD_VALID SHALL be ignored while RST=0.

Verification
REQ-028 Reset then load 10'b0100011100 -> DATA over 10 cycles = 0,0,1,1,1,0,0,0,1,0, DONE high on the 10th, then 3 cycles DATA_VALID=0, WORD_CNT=1.
REQ-029 Load 10'b1110001010 while the first word shifts -> LOAD_READY=0 until the transfer; second word starts exactly after the 3 gap cycles; WORD_CNT=2.
REQ-030 GAP_CYCLES=0 build, words 10'b0101010101 and 10'b1111111111 queued -> 20 consecutive DATA_VALID=1 cycles, DATA = 1,0 repeated five times then 1 ten times.
REQ-031 RST=0 during bit 4 of 10'b1010000111 -> next cycle DATA=0, BUSY=0, WORD_CNT unchanged, LOAD_READY=1; a reload afterward sends the full word from bit 0.
REQ-032 Send 256 words of 10'b0000000000 -> DATA stays 0, DATA_VALID pattern 10 on / 3 off, WORD_CNT wraps to 0.
REQ-033 Hold LOAD_VALID=1 with changing WORD while hold_full=1 -> the held value is unchanged, and only accepted words appear on DATA.

Source files
------------

// File: rtl/seq_tx.sv
// Serialiser: a one-entry holding register feeds a shift register that sends
// WIDTH bits LSB-first, followed by GAP_CYCLES idle bit-times per word.
module seq_tx #(
    parameter int WIDTH      = 10,
    parameter int GAP_CYCLES = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] WORD,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             DATA,
    output logic             DATA_VALID,
    output logic             DONE,
    output logic             BUSY,
    output logic [7:0]       WORD_CNT
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] ONE_B    = BW'(1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0] ONE_G    = GW'(1);
    localparam bit            HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             load_ready_reg;
    logic             data_reg;
    logic             data_valid_reg;
    logic             done_reg;
    logic             busy_reg;
    logic [7:0]       word_cnt_reg;

    logic             last_bit;
    logic             gap_end;
    logic             slot_free;
    logic             take_hold;
    logic             accept;
    logic             hold_full_next;

    // slot_free marks an edge on which the line may start the held word:
    // idle, the final gap cycle, or the last bit itself when there is no gap.
    always_comb begin
        last_bit       = (state_reg == SHIFT) && (bit_cnt_reg == LAST_BIT);
        gap_end        = (state_reg == GAP) && (gap_cnt_reg == LAST_GAP);
        slot_free      = (state_reg == IDLE) || gap_end || (last_bit && !HAS_GAP);
        take_hold      = hold_full_reg && slot_free;
        accept         = LOAD_VALID && load_ready_reg;
        hold_full_next = accept || (hold_full_reg && !take_hold);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            load_ready_reg <= 1'b1;
            data_reg       <= 1'b0;
            data_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            word_cnt_reg   <= 8'd0;
        end else begin
            if (accept) begin
                hold_reg <= WORD;
            end
            hold_full_reg  <= hold_full_next;
            load_ready_reg <= !hold_full_next;
            done_reg       <= 1'b0;

            if (last_bit) begin
                word_cnt_reg <= word_cnt_reg + 8'd1;
            end

            if (take_hold) begin
                // Bit 0 goes straight to the line; the rest waits in shift_reg.
                state_reg      <= SHIFT;
                shift_reg      <= hold_reg >> 1;
                bit_cnt_reg    <= '0;
                data_reg       <= hold_reg[0];
                data_valid_reg <= 1'b1;
                done_reg       <= (LAST_BIT == '0);
                busy_reg       <= 1'b1;
            end else begin
                case (state_reg)
                    SHIFT: begin
                        if (last_bit) begin
                            data_reg       <= 1'b0;
                            data_valid_reg <= 1'b0;
                            gap_cnt_reg    <= '0;
                            if (HAS_GAP) begin
                                state_reg <= GAP;
                                busy_reg  <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_reg    <= bit_cnt_reg + ONE_B;
                            shift_reg      <= shift_reg >> 1;
                            data_reg       <= shift_reg[0];
                            data_valid_reg <= 1'b1;
                            done_reg       <= ((bit_cnt_reg + ONE_B) == LAST_BIT);
                            busy_reg       <= 1'b1;
                        end
                    end
                    GAP: begin
                        data_reg       <= 1'b0;
                        data_valid_reg <= 1'b0;
                        if (gap_end) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + ONE_G;
                            busy_reg    <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg      <= IDLE;
                        data_reg       <= 1'b0;
                        data_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign LOAD_READY = load_ready_reg;
    assign DATA       = data_reg;
    assign DATA_VALID = data_valid_reg;
    assign DONE       = done_reg;
    assign BUSY       = busy_reg;
    assign WORD_CNT   = word_cnt_reg;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: a gap-3 and a gap-0 instance share stimulus and are
// compared every cycle against a word/position timeline model.
module tb_seq_tx;

    localparam int W = 10;

    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         lv = 1'b0;
    logic [W-1:0] word = '0;

    logic ready3, data3, dv3, done3, busy3;
    logic [7:0] cnt3;
    logic ready0, data0, dv0, done0, busy0;
    logic [7:0] cnt0;

    seq_tx #(.WIDTH(W), .GAP_CYCLES(3)) dut (
        .CLK(CLK), .RST(rst_n), .WORD(word), .LOAD_VALID(lv), .LOAD_READY(ready3),
        .DATA(data3), .DATA_VALID(dv3), .DONE(done3), .BUSY(busy3), .WORD_CNT(cnt3)
    );

    seq_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(rst_n), .WORD(word), .LOAD_VALID(lv), .LOAD_READY(ready0),
        .DATA(data0), .DATA_VALID(dv0), .DONE(done0), .BUSY(busy0), .WORD_CNT(cnt0)
    );

    always #5 CLK = ~CLK;

    logic [12:0] obs3, obs0;
    assign obs3 = {data3, dv3, done3, busy3, ready3, cnt3};
    assign obs0 = {data0, dv0, done0, busy0, ready0, cnt0};

    // A word occupies W+gap slots; pos is the slot index while active.
    typedef struct {
        bit           active;
        int           pos;
        logic [W-1:0] wd;
        bit           held;
        logic [W-1:0] hwd;
        logic [7:0]   cnt;
        int           acc;
    } model_t;

    model_t m3, m0;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    function automatic void model_step(inout model_t m, input int gap, input bit rn,
                                       input bit v, input logic [W-1:0] w);
        bit acc_now, free;
        if (!rn) begin
            m.active = 0; m.pos = 0; m.wd = '0; m.held = 0; m.hwd = '0; m.cnt = 8'd0;
            return;
        end
        acc_now = v && !m.held;
        free = !m.active || (m.pos == W + gap - 1);
        if (m.active && m.pos == W - 1) m.cnt = m.cnt + 8'd1;
        if (m.active) m.pos = m.pos + 1;
        if (free) m.active = 0;
        if (free && m.held) begin
            m.active = 1; m.pos = 0; m.wd = m.hwd; m.held = 0;
        end
        if (acc_now) begin
            m.held = 1; m.hwd = w; m.acc = m.acc + 1;
        end
    endfunction

    function automatic logic [12:0] exp_vec(input model_t m);
        logic d, v, dn;
        v  = m.active && (m.pos < W);
        d  = v ? m.wd[m.pos] : 1'b0;
        dn = m.active && (m.pos == W - 1);
        return {d, v, dn, m.active, !m.held, m.cnt};
    endfunction

    task automatic step();
        @(posedge CLK);
        model_step(m3, 3, rst_n, lv, word);
        model_step(m0, 0, rst_n, lv, word);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lv = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lv = 1'b1;
        word = W'($urandom);
        repeat (3) step();
        n_vec++;
        if ({obs3, obs0} !== {13'h100, 13'h100}) begin
            n_err++;
            $display("FAIL reset_state cyc=%0d got=%h/%h want=100/100", cyc, obs3, obs0);
        end
        n_vec++;
        if ({obs3, obs0} !== {exp_vec(m3), exp_vec(m0)}) begin
            n_err++;
            $display("FAIL reset_model cyc=%0d got=%h/%h", cyc, obs3, obs0);
        end
        rst_n = 1'b1;
        lv = 1'b0;
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_single();
        int exp_seq[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
        lv = 1'b1;
        word = 10'b0100011100;
        step();
        lv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if ({obs3, obs0} !== {exp_vec(m3), exp_vec(m0)}) begin
                n_err++;
                $display("FAIL single_model cyc=%0d got=%h/%h want=%h/%h", cyc, obs3, obs0, exp_vec(m3), exp_vec(m0));
            end
            n_vec++;
            if (data3 !== exp_seq[i][0] || dv3 !== 1'b1 || done3 !== (i == 9)) begin
                n_err++;
                $display("FAIL single_bit%0d got data=%b dv=%b done=%b want data=%0d dv=1 done=%0d",
                         i, data3, dv3, done3, exp_seq[i], (i == 9));
            end
        end
        for (int g = 0; g < 3; g++) begin
            step();
            n_vec++;
            if (dv3 !== 1'b0 || data3 !== 1'b0 || busy3 !== 1'b1 || cnt3 !== 8'd1) begin
                n_err++;
                $display("FAIL single_gap%0d got dv=%b data=%b busy=%b cnt=%0d want 0 0 1 1", g, dv3, data3, busy3, cnt3);
            end
        end
        step();
        n_vec++;
        if (busy3 !== 1'b0 || dv3 !== 1'b0 || cnt3 !== 8'd1) begin
            n_err++;
            $display("FAIL single_idle got busy=%b dv=%b cnt=%0d want 0 0 1", busy3, dv3, cnt3);
        end
        $display("test_single word 0x%h sent at cycle %0d", 10'b0100011100, cyc);
    endtask

    task automatic test_queued();
        logic [W-1:0] a, b;
        do_reset();
        a = W'($urandom);
        b = 10'b1110001010;
        lv = 1'b1;
        word = a;
        step();
        lv = 1'b0;
        step();
        n_vec++;
        if (ready3 !== 1'b1 || data3 !== a[0]) begin
            n_err++;
            $display("FAIL queued_first got ready=%b data=%b want 1 %b", ready3, data3, a[0]);
        end
        lv = 1'b1;
        word = b;
        step();
        lv = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            step();
            n_vec++;
            if (obs3 !== exp_vec(m3)) begin
                n_err++;
                $display("FAIL queued_model k=%0d got=%h want=%h", k, obs3, exp_vec(m3));
            end
            if (k <= 11) begin
                n_vec++;
                if (ready3 !== 1'b0) begin
                    n_err++;
                    $display("FAIL queued_ready k=%0d got=%b want 0", k, ready3);
                end
            end
            if (k >= 9 && k <= 11) begin
                n_vec++;
                if (dv3 !== 1'b0) begin
                    n_err++;
                    $display("FAIL queued_gap k=%0d got dv=%b want 0", k, dv3);
                end
            end
            if (k >= 12 && k <= 21) begin
                n_vec++;
                if (dv3 !== 1'b1 || data3 !== b[k-12]) begin
                    n_err++;
                    $display("FAIL queued_b_bit%0d got dv=%b data=%b want 1 %b", k - 12, dv3, data3, b[k-12]);
                end
            end
        end
        n_vec++;
        if (cnt3 !== 8'd2) begin
            n_err++;
            $display("FAIL queued_cnt got=%0d want=2", cnt3);
        end
        $display("test_queued words 0x%h,0x%h sent at cycle %0d", a, b, cyc);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r;
        do_reset();
        r = 10'b1010000111;
        lv = 1'b1;
        word = r;
        step();
        lv = 1'b0;
        repeat (5) step();
        n_vec++;
        if (data3 !== r[4] || dv3 !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_bit4 got data=%b dv=%b want %b 1", data3, dv3, r[4]);
        end
        rst_n = 1'b0;
        lv = 1'b1;
        word = W'($urandom);
        step();
        n_vec++;
        if (data3 !== 1'b0 || dv3 !== 1'b0 || busy3 !== 1'b0 || cnt3 !== 8'd0 || ready3 !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_state got data=%b dv=%b busy=%b cnt=%0d ready=%b want 0 0 0 0 1",
                     data3, dv3, busy3, cnt3, ready3);
        end
        rst_n = 1'b1;
        word = r;
        step();
        lv = 1'b0;
        for (int i = 0; i < W; i++) begin
            step();
            n_vec++;
            if (data3 !== r[i] || dv3 !== 1'b1 || {obs3, obs0} !== {exp_vec(m3), exp_vec(m0)}) begin
                n_err++;
                $display("FAIL rstmid_reload_bit%0d got data=%b dv=%b want %b 1", i, data3, dv3, r[i]);
            end
        end
        $display("test_reset_mid reload 0x%h sent at cycle %0d", r, cyc);
    endtask

    task automatic test_back_to_back();
        bit want;
        do_reset();
        lv = 1'b1;
        word = 10'b0101010101;
        step();
        word = 10'b1111111111;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 1) lv = 1'b0;
            want = (i < 10) ? (i % 2 == 0) : 1'b1;
            n_vec++;
            if (dv0 !== 1'b1 || data0 !== want || {obs3, obs0} !== {exp_vec(m3), exp_vec(m0)}) begin
                n_err++;
                $display("FAIL b2b_bit%0d got dv=%b data=%b want 1 %b", i, dv0, data0, want);
            end
        end
        step();
        n_vec++;
        if (dv0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 8'd2) begin
            n_err++;
            $display("FAIL b2b_end got dv=%b busy=%b cnt=%0d want 0 0 2", dv0, busy0, cnt0);
        end
        $display("test_back_to_back two words streamed at cycle %0d", cyc);
    endtask

    task automatic test_hold_stable();
        do_reset();
        lv = 1'b1;
        for (int i = 0; i < 80; i++) begin
            word = W'($urandom);
            step();
            n_vec++;
            if ({obs3, obs0} !== {exp_vec(m3), exp_vec(m0)}) begin
                n_err++;
                $display("FAIL hold_model cyc=%0d got=%h/%h want=%h/%h", cyc, obs3, obs0, exp_vec(m3), exp_vec(m0));
            end
        end
        lv = 1'b0;
        $display("test_hold_stable done at cycle %0d", cyc);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            lv = 1'($urandom);
            word = W'($urandom);
            rst_n = ($urandom_range(0, 63) != 0);
            step();
            n_vec++;
            if ({obs3, obs0} !== {exp_vec(m3), exp_vec(m0)}) begin
                n_err++;
                $display("FAIL random_model cyc=%0d got=%h/%h want=%h/%h", cyc, obs3, obs0, exp_vec(m3), exp_vec(m0));
            end
        end
        rst_n = 1'b1;
        lv = 1'b0;
        $display("test_random done at cycle %0d", cyc);
    endtask

    task automatic test_wrap();
        int done_cnt = 0;
        int dv_cnt = 0;
        bit fin = 0;
        do_reset();
        m3.acc = 0;
        lv = 1'b1;
        word = '0;
        for (int c = 0; c < 5000 && !fin; c++) begin
            step();
            if (m3.acc >= 256) lv = 1'b0;
            if (done3 === 1'b1) done_cnt++;
            if (dv3 === 1'b1) dv_cnt++;
            n_vec++;
            if (obs3 !== exp_vec(m3) || data3 !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_model cyc=%0d got=%h want=%h", cyc, obs3, exp_vec(m3));
            end
            fin = (m3.acc >= 256) && !m3.active && !m3.held;
        end
        n_vec++;
        if (!fin || done_cnt != 256 || dv_cnt != 2560 || cnt3 !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_end got fin=%0d done=%0d dv=%0d cnt=%0d want 1 256 2560 0",
                     fin, done_cnt, dv_cnt, cnt3);
        end
        $display("test_wrap 256 words sent at cycle %0d", cyc);
    endtask

    initial begin
        m3 = '{default: 0};
        m0 = '{default: 0};
        test_reset();
        test_single();
        test_queued();
        test_reset_mid();
        test_back_to_back();
        test_hold_stable();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
